// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register: extracts and extends load data,
// qualifies the register write, flags bad loads and counts retired instructions.
module mem_wb_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic [WIDTH-1:0] alu_result_m,
    input  logic [WIDTH-1:0] read_data_m,
    input  logic [WIDTH-1:0] pc_plus4_m,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [1:0]       result_src_m,
    input  logic [2:0]       funct3_m,
    output logic             valid_w,
    output logic [WIDTH-1:0] alu_result_w,
    output logic [WIDTH-1:0] read_data_w,
    output logic [WIDTH-1:0] pc_plus4_w,
    output logic [4:0]       rd_w,
    output logic             reg_write_w,
    output logic [1:0]       result_src_w,
    output logic             load_err_w,
    output logic [31:0]      instret_w
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_ILL  = 2'b11;

    // Reserved funct3 codes and misaligned halfword/word accesses are faults.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3)
            3'b000, 3'b100: r = 1'b0;
            3'b001, 3'b101: r = off[0];
            3'b010:         r = (off != 2'b00);
            default:        r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] extract_load(input logic [2:0] f3,
                                                      input logic [1:0] off,
                                                      input logic [WIDTH-1:0] word);
        logic [7:0]       b;
        logic [15:0]      h;
        logic [WIDTH-1:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = word[7:0];
        endcase
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic             is_load_s;
    logic             load_err_s;
    logic [WIDTH-1:0] load_data_s;
    logic [1:0]       src_s;
    logic             wen_s;
    logic [31:0]      instret_inc_s;

    assign instret_inc_s = instret_w + 32'd1;

    // Decode the M-stage instruction into the values the W registers capture.
    always_comb begin
        is_load_s   = (result_src_m == SRC_LOAD);
        load_err_s  = 1'b0;
        load_data_s = {WIDTH{1'b0}};
        if (is_load_s) begin
            load_err_s = load_fault(funct3_m, alu_result_m[1:0]);
        end else begin
            load_err_s = 1'b0;
        end
        if (is_load_s && !load_err_s) begin
            load_data_s = extract_load(funct3_m, alu_result_m[1:0], read_data_m);
        end else begin
            load_data_s = {WIDTH{1'b0}};
        end
        // Illegal select is steered to the ALU leg so the mux never sees 11.
        if (result_src_m == SRC_ILL) begin
            src_s = SRC_ALU;
        end else begin
            src_s = result_src_m;
        end
        wen_s = reg_write_m & ~load_err_s & (result_src_m != SRC_ILL) & (rd_m != 5'd0);
    end

    // W-stage registers: reset > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_w      <= 1'b0;
            alu_result_w <= {WIDTH{1'b0}};
            read_data_w  <= {WIDTH{1'b0}};
            pc_plus4_w   <= {WIDTH{1'b0}};
            rd_w         <= 5'd0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            load_err_w   <= 1'b0;
            instret_w    <= 32'd0;
        end else if (flush_w || (!stall_w && !valid_m)) begin
            valid_w      <= 1'b0;
            alu_result_w <= {WIDTH{1'b0}};
            read_data_w  <= {WIDTH{1'b0}};
            pc_plus4_w   <= {WIDTH{1'b0}};
            rd_w         <= 5'd0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            load_err_w   <= 1'b0;
            instret_w    <= instret_w;
        end else if (stall_w) begin
            valid_w      <= valid_w;
            alu_result_w <= alu_result_w;
            read_data_w  <= read_data_w;
            pc_plus4_w   <= pc_plus4_w;
            rd_w         <= rd_w;
            reg_write_w  <= reg_write_w;
            result_src_w <= result_src_w;
            load_err_w   <= load_err_w;
            instret_w    <= instret_w;
        end else begin
            valid_w      <= 1'b1;
            alu_result_w <= alu_result_m;
            read_data_w  <= load_data_s;
            pc_plus4_w   <= pc_plus4_m;
            rd_w         <= rd_m;
            reg_write_w  <= wen_s;
            result_src_w <= src_s;
            load_err_w   <= load_err_s;
            if (load_err_s) begin
                instret_w <= instret_w;
            end else begin
                instret_w <= instret_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage with a behavioural reference model,
// a per-cycle compare process and directed literal checks.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_w, flush_w, valid_m, reg_write_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic        valid_w, reg_write_w, load_err_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus4_w, instret_w;
    logic [4:0]  rd_w;
    logic [1:0]  result_src_w;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;
    bit force_wrap = 1'b0;

    // model state
    logic        e_valid, e_we, e_err;
    logic [31:0] e_alu, e_data, e_pc, e_cnt;
    logic [4:0]  e_rd;
    logic [1:0]  e_src;

    mem_wb_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .funct3_m(funct3_m),
        .valid_w(valid_w), .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .pc_plus4_w(pc_plus4_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .load_err_w(load_err_w), .instret_w(instret_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && off[0]) return 1'b1;
        if (f3 == 3'd2 && off != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] bsh, hsh;
        bsh = word >> (8 * int'(off));
        hsh = word >> (16 * int'(off[1]));
        case (f3)
            3'd0: return 32'($signed(bsh[7:0]));
            3'd4: return 32'(bsh[7:0]);
            3'd1: return 32'($signed(hsh[15:0]));
            3'd5: return 32'(hsh[15:0]);
            3'd2: return word;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: what the W stage must hold after each edge.
    always @(posedge clk) begin
        bit ld, err;
        ld  = (result_src_m == 2'b01);
        err = ld && model_err(funct3_m, alu_result_m[1:0]);
        if (!rst_n) begin
            {e_valid, e_we, e_err, e_rd, e_src} <= '0;
            e_alu <= 32'd0; e_data <= 32'd0; e_pc <= 32'd0; e_cnt <= 32'd0;
        end else if (flush_w || (!stall_w && !valid_m)) begin
            {e_valid, e_we, e_err, e_rd, e_src} <= '0;
            e_alu <= 32'd0; e_data <= 32'd0; e_pc <= 32'd0;
        end else if (!stall_w) begin
            e_valid <= 1'b1;
            e_alu   <= alu_result_m;
            e_pc    <= pc_plus4_m;
            e_rd    <= rd_m;
            e_err   <= err;
            e_src   <= (result_src_m == 2'b11) ? 2'b00 : result_src_m;
            e_data  <= (ld && !err) ? model_data(funct3_m, alu_result_m[1:0], read_data_m) : 32'd0;
            e_we    <= reg_write_m && !err && result_src_m != 2'b11 && rd_m != 5'd0;
            if (!err) e_cnt <= force_wrap ? 32'hFFFF_FFFF : e_cnt + 32'd1;
        end
    end

    // Compare every W output against the model once per cycle.
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid_w", 32'(valid_w), 32'(e_valid));
            chk("alu_result_w", alu_result_w, e_alu);
            chk("read_data_w", read_data_w, e_data);
            chk("pc_plus4_w", pc_plus4_w, e_pc);
            chk("rd_w", 32'(rd_w), 32'(e_rd));
            chk("reg_write_w", 32'(reg_write_w), 32'(e_we));
            chk("result_src_w", 32'(result_src_w), 32'(e_src));
            chk("load_err_w", 32'(load_err_w), 32'(e_err));
            chk("instret_w", instret_w, e_cnt);
        end
    end

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [4:0] rd, input logic we, input logic [1:0] src,
                         input logic [2:0] f3);
        valid_m = v; alu_result_m = alu; read_data_m = rdat; pc_plus4_m = alu ^ 32'h0000_4444;
        rd_m = rd; reg_write_m = we; result_src_m = src; funct3_m = f3;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        drive(1'b1, 32'h1234_5678, 32'hAAAA_5555, 5'd9, 1'b1, 2'b01, 3'b010);
        tick();
        check_en = 1'b1;
        tick();
        chk("reset_valid", 32'(valid_w), 32'd0);
        chk("reset_instret", instret_w, 32'd0);
        chk("reset_alu", alu_result_w, 32'd0);

        rst_n = 1'b1;
        drive(1'b1, 32'h0000_1003, 32'h80FF_1234, 5'd5, 1'b1, 2'b01, 3'b000);
        tick();
        chk("lb_data", read_data_w, 32'hFFFF_FF80);
        chk("lb_we", 32'(reg_write_w), 32'd1);
        chk("lb_instret", instret_w, 32'd1);

        drive(1'b1, 32'h0000_0001, 32'h80FF_1234, 5'd6, 1'b1, 2'b01, 3'b101);
        tick();
        chk("lhu_err", 32'(load_err_w), 32'd1);
        chk("lhu_data", read_data_w, 32'd0);
        chk("lhu_we", 32'(reg_write_w), 32'd0);
        chk("lhu_instret", instret_w, 32'd1);

        drive(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000);
        tick();
        stall_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 5'($urandom), 1'b1, 2'($urandom), 3'($urandom));
            tick();
            chk("stall_alu", alu_result_w, 32'hDEAD_BEEF);
            chk("stall_instret", instret_w, 32'd2);
        end
        flush_w = 1'b1;
        tick();
        chk("flush_valid", 32'(valid_w), 32'd0);
        chk("flush_we", 32'(reg_write_w), 32'd0);
        chk("flush_alu", alu_result_w, 32'd0);
        chk("flush_instret", instret_w, 32'd2);
        stall_w = 1'b0; flush_w = 1'b0;

        drive(1'b1, 32'h0000_0010, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000);
        tick();
        chk("x0_we", 32'(reg_write_w), 32'd0);
        chk("x0_instret", instret_w, 32'd3);
        drive(1'b1, 32'h0000_0020, 32'h0, 5'd4, 1'b1, 2'b11, 3'b000);
        tick();
        chk("ill_src", 32'(result_src_w), 32'd0);
        chk("ill_we", 32'(reg_write_w), 32'd0);

        drive(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 5'd7, 1'b1, 2'b01, 3'b010);
        stall_w = 1'b1; rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(valid_w), 32'd0);
        chk("midrst_instret", instret_w, 32'd0);
        chk("midrst_rd", 32'(rd_w), 32'd0);
        rst_n = 1'b1; stall_w = 1'b0;
        drive(1'b1, 32'h0000_0104, 32'h1234_5678, 5'd7, 1'b1, 2'b01, 3'b010);
        tick();
        chk("post_rst_data", read_data_w, 32'h1234_5678);
        chk("post_rst_instret", instret_w, 32'd1);

        force dut.instret_inc_s = 32'hFFFF_FFFF;
        force_wrap = 1'b1;
        drive(1'b1, 32'h0000_0040, 32'h0, 5'd2, 1'b1, 2'b00, 3'b000);
        tick();
        release dut.instret_inc_s;
        force_wrap = 1'b0;
        chk("preload_instret", instret_w, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_0044, 32'h0, 5'd2, 1'b1, 2'b10, 3'b000);
        tick();
        chk("wrap_instret", instret_w, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            rst_n   = ($urandom_range(0, 99) != 0);
            stall_w = ($urandom_range(0, 99) < 15);
            flush_w = ($urandom_range(0, 99) < 8);
            drive(($urandom_range(0, 9) != 0), a, $urandom, 5'($urandom),
                  1'($urandom), ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom),
                  3'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (only 32 is supported).
REQ-002 SHALL have the following ports; clock is clk, reset is rst_n, one clock, reset synchronous and active-low:
  clk             input   1      rising-edge clock
  rst_n           input   1      synchronous active-low reset
  stall_w         input   1      hold all W-stage registers
  flush_w         input   1      load a bubble into W stage
  valid_m         input   1      M-stage instruction valid
  alu_result_m    input   WIDTH  ALU result / load address
  read_data_m     input   WIDTH  raw aligned word from data memory
  pc_plus4_m      input   WIDTH  PC+4 of M-stage instruction
  rd_m            input   5      destination register
  reg_write_m     input   1      register-write enable
  result_src_m    input   2      00 ALU, 01 load, 10 PC+4, 11 illegal
  funct3_m        input   3      load type
  valid_w         output  1      W-stage instruction valid
  alu_result_w    output  WIDTH  registered ALU result
  read_data_w     output  WIDTH  extracted, extended load data
  pc_plus4_w      output  WIDTH  registered PC+4
  rd_w            output  5      registered destination
  reg_write_w     output  1      qualified write enable
  result_src_w    output  2      select for the 3-input writeback multiplexer
  load_err_w      output  1      misaligned or illegal load flag
  instret_w       output  32     retired-instruction counter

Function
REQ-003 SHALL register all outputs on rising clk edge; latency 1 cycle from M inputs to W outputs.
REQ-004 SHALL apply priority per edge: reset > flush_w > stall_w > capture.
REQ-005 SHALL on flush_w=1 (including flush_w=1 with stall_w=1) load a bubble: every output register except instret_w set to 0.
REQ-006 SHALL on stall_w=1, flush_w=0 hold every output register unchanged, including instret_w.
REQ-007 SHALL on capture with valid_m=0 load a bubble, per REQ-005.
REQ-008 SHALL on capture with valid_m=1 load alu_result_m, pc_plus4_m, rd_m, result_src_m into the matching W registers and set valid_w=1.
REQ-009 SHALL extract load data only when result_src_m=01, using offset = alu_result_m[1:0]: LB 000 / LBU 100 select byte[offset] and sign-/zero-extend it; LH 001 / LHU 101 select halfword[offset[1]] and sign-/zero-extend it; LW 010 passes the full word.
REQ-010 SHALL set read_data_w=0 when result_src_m!=01.
REQ-011 SHALL flag load_err_w=1 when result_src_m=01 and any of: LH/LHU with offset[0]=1; LW with offset!=00; funct3 in {011,110,111}. read_data_w SHALL then be 0.
REQ-012 SHALL compute reg_write_w = reg_write_m AND valid_m AND NOT load_err AND (result_src_m!=11) AND (rd_m!=0).
REQ-013 SHALL replace result_src_m=11 with result_src_w=00, so the downstream multiplexer never receives 11.
REQ-014 SHALL increment instret_w by 1 on each capture with valid_m=1 and no load error; wraps FFFFFFFF->0; no increment on bubble, stall, flush or error.
REQ-015 SHALL keep load_err_w as a registered one-cycle flag per captured instruction, held during stall.

Reset
REQ-016 SHALL on rst_n=0 at a clock edge set every output, including instret_w, to 0, regardless of stall_w/flush_w.
REQ-017 SHALL, after rst_n deasserts mid-stream, begin capture on the first edge with rst_n=1; in-flight M data present during reset is discarded.

Verification
REQ-018 LB: result_src_m=01, funct3=000, alu_result_m=0x1003, read_data_m=0x80FF_1234, rd_m=5, reg_write_m=1 -> next cycle read_data_w=0xFFFF_FF80, reg_write_w=1, instret_w+1.
REQ-019 LHU misaligned: funct3=101, alu_result_m=0x0001 -> load_err_w=1, read_data_w=0, reg_write_w=0, instret_w unchanged.
REQ-020 Stall then flush: capture an ALU op (alu_result_m=0xDEAD_BEEF); stall_w=1 for 3 cycles -> outputs held; then flush_w=1 with stall_w=1 -> valid_w=0, reg_write_w=0, alu_result_w=0.
REQ-021 Write to x0 and illegal select: rd_m=0, reg_write_m=1 -> reg_write_w=0 and instret increments; result_src_m=11 -> result_src_w=00, reg_write_w=0.
REQ-022 Counter wrap: preload instret_w to 0xFFFF_FFFF via retirements (or force), retire one valid op -> instret_w=0.
REQ-023 Reset mid-operation: rst_n=0 for one edge during a valid LW capture with stall_w=1 -> all outputs 0; first edge after release captures the current M inputs.
